basic_fifo: RTL and testbench

- Synchronous single-clock FIFO with show-ahead read data and occupancy flags; depth is 2^ADDR_WIDTH.
- Used as the decoded-instruction queue feeding instruction issue, and as a generic buffer elsewhere.
- almost_full is used for upstream back-pressure, so it asserts while spare slots remain.
- clear flushes all contents in one cycle, for example on branch redirect.

---
 rtl/basic_fifo.sv | 56 +++++
 tb/tb_basic_fifo.sv | 109 ++++++++++
 2 files changed

// File: rtl/basic_fifo.sv
// basic_fifo: single-clock show-ahead FIFO with occupancy flags
// Head entry is always visible on rd_data; clear flushes in one cycle.
module basic_fifo #(
   parameter int ADDR_WIDTH             = 4,
   parameter int DATA_WIDTH             = 32,
   parameter int ALMOST_FULL_THRESHOLD  = (1 << ADDR_WIDTH) - 4,
   parameter int ALMOST_EMPTY_THRESHOLD = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  clear,
   input  logic                  push,
   input  logic                  pop,
   input  logic [DATA_WIDTH-1:0] wr_data,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  empty,
   output logic                  full,
   output logic                  almost_empty,
   output logic                  almost_full
);
   localparam logic [ADDR_WIDTH:0] L_DEPTH = (ADDR_WIDTH + 1)'(1 << ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0] L_AF    = (ADDR_WIDTH + 1)'(ALMOST_FULL_THRESHOLD);
   localparam logic [ADDR_WIDTH:0] L_AE    = (ADDR_WIDTH + 1)'(ALMOST_EMPTY_THRESHOLD);

   logic [DATA_WIDTH-1:0] r_mem [1 << ADDR_WIDTH];
   logic [ADDR_WIDTH-1:0] r_wptr, r_rptr;
   logic [ADDR_WIDTH:0]   r_count;
   logic                  w_push, w_pop;

   // a pop frees the head slot, so a push into a full FIFO may proceed alongside it
   assign w_pop  = pop && !empty;
   assign w_push = push && (!full || w_pop);

   always_ff @(posedge clk) begin
      if (rst || clear) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= r_wptr + ADDR_WIDTH'(1);
         if (w_pop)  r_rptr <= r_rptr + ADDR_WIDTH'(1);
         r_count <= r_count + {{ADDR_WIDTH{1'b0}}, w_push & ~w_pop}
                            - {{ADDR_WIDTH{1'b0}}, w_pop & ~w_push};
      end
   end

   always_ff @(posedge clk) begin
      if (w_push && !rst && !clear) r_mem[r_wptr] <= wr_data;
   end

   assign rd_data      = r_mem[r_rptr];
   assign empty        = r_count == '0;
   assign full         = r_count == L_DEPTH;
   assign almost_empty = r_count <= L_AE;
   assign almost_full  = r_count >= L_AF;
endmodule

// File: tb/tb_basic_fifo.sv
// tb_basic_fifo: vector table with hand-derived flags plus a data scoreboard
// Depth 8, almost_full at 6, almost_empty at 1.
module tb_basic_fifo;
   typedef struct {
      logic [2:0] op;
      logic [7:0] d;
      logic [3:0] fl;
   } vec_t;

   logic       clk = 1'b0;
   logic       rst, clear, push, pop;
   logic [7:0] wr_data, rd_data;
   logic       empty, full, almost_empty, almost_full;
   int         n_vec = 0;
   int         n_err = 0;
   vec_t       v[$];
   logic [7:0] q[$];

   basic_fifo #(
      .ADDR_WIDTH(3),
      .DATA_WIDTH(8),
      .ALMOST_FULL_THRESHOLD(6),
      .ALMOST_EMPTY_THRESHOLD(1)
   ) dut (
      .clk(clk), .rst(rst), .clear(clear), .push(push), .pop(pop),
      .wr_data(wr_data), .rd_data(rd_data), .empty(empty), .full(full),
      .almost_empty(almost_empty), .almost_full(almost_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic [2:0] op, input logic [7:0] d, input logic [3:0] fl);
      v.push_back('{op, d, fl});
   endtask

   // apply one cycle, update the scoreboard, then check flags and head data
   task automatic step(input logic [2:0] op, input logic [7:0] d, input logic [3:0] fl, input string name);
      logic ep, epu;
      @(negedge clk);
      {clear, push, pop} = op;
      wr_data = d;
      ep  = pop && q.size() > 0;
      epu = push && (q.size() < 8 || ep);
      @(posedge clk);
      #1;
      if (clear) q.delete();
      else begin
         if (ep) void'(q.pop_front());
         if (epu) q.push_back(d);
      end
      check({name, " flags{e,f,ae,af}"}, {4'b0, empty, full, almost_empty, almost_full}, {4'b0, fl});
      if (q.size() > 0) check({name, " rd_data"}, rd_data, q[0]);
   endtask

   initial begin
      rst = 1'b1; clear = 1'b0; push = 1'b0; pop = 1'b0; wr_data = '0;
      repeat (2) @(posedge clk);
      #1;
      check("reset flags", {4'b0, empty, full, almost_empty, almost_full}, 8'b1010);
      @(negedge clk);
      rst = 1'b0;
      // op = {clear,push,pop}, fl = {empty,full,almost_empty,almost_full}
      add(3'b000, 8'h00, 4'b1010);
      add(3'b010, 8'h11, 4'b0010);
      add(3'b010, 8'h22, 4'b0000);
      add(3'b001, 8'h00, 4'b0010);
      add(3'b001, 8'h00, 4'b1010);
      for (int i = 0; i < 8; i++)
         add(3'b010, 8'(i), i == 0 ? 4'b0010 : i == 7 ? 4'b0101 : i >= 5 ? 4'b0001 : 4'b0000);
      add(3'b010, 8'hFF, 4'b0101);
      add(3'b011, 8'hAA, 4'b0101);
      for (int i = 7; i >= 0; i--)
         add(3'b001, 8'h00, i == 0 ? 4'b1010 : i == 1 ? 4'b0010 : i >= 6 ? 4'b0001 : 4'b0000);
      add(3'b001, 8'h00, 4'b1010);
      add(3'b011, 8'h44, 4'b0010);
      add(3'b001, 8'h00, 4'b1010);
      for (int i = 1; i <= 5; i++)
         add(3'b010, 8'(8'h60 + i), i == 1 ? 4'b0010 : 4'b0000);
      add(3'b110, 8'h55, 4'b1010);
      add(3'b010, 8'h33, 4'b0010);
      add(3'b001, 8'h00, 4'b1010);
      for (int i = 0; i < v.size(); i++)
         step(v[i].op, v[i].d, v[i].fl, $sformatf("vec%0d", i));
      // reset in the middle of a fill must return every flag to its reset value
      for (int i = 0; i < 6; i++)
         step(3'b010, 8'(8'hB0 + i), i == 0 ? 4'b0010 : i == 5 ? 4'b0001 : 4'b0000, $sformatf("fill%0d", i));
      @(negedge clk);
      push = 1'b0;
      rst = 1'b1;
      @(posedge clk);
      #1;
      q.delete();
      check("mid-fill reset flags", {4'b0, empty, full, almost_empty, almost_full}, 8'b1010);
      @(negedge clk);
      rst = 1'b0;
      step(3'b010, 8'h77, 4'b0010, "post-reset push");
      step(3'b001, 8'h00, 4'b1010, "post-reset pop");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
